// File: rtl/regfile_2r1w_if.sv
// Register-file access bundle: one write port and two combinational read ports.
interface regfile_2r1w_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic          we;
  logic [AW-1:0] wn;
  logic [DW-1:0] d;
  logic [AW-1:0] rna;
  logic [AW-1:0] rnb;
  logic [DW-1:0] qa;
  logic [DW-1:0] qb;

  modport master (output we, wn, d, rna, rnb, input qa, qb);
  modport slave  (input we, wn, d, rna, rnb, output qa, qb);
endinterface

// File: rtl/regfile_2r1w.sv
// 2-read / 1-write general-purpose register file with r0 hard-wired to zero
// and optional same-cycle write-to-read forwarding.
module regfile_2r1w #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 5,
  parameter bit          BYPASS = 1'b1
) (
  input logic                 clk,
  input logic                 clrn,
  regfile_2r1w_if.slave       bus
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] regs [1:DEPTH-1];
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
  logic          wr_valid_c;
  logic          fwd_a;
  logic          fwd_b;

  assign wr_valid_c = bus.we && (bus.wn != '0);

  // Compare-per-entry write decode keeps an unknown wn harmless while we=0.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 1; i < int'(DEPTH); i++) regs[i] <= '0;
    end else if (wr_valid_c) begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (bus.wn == AW'(i)) regs[i] <= bus.d;
      end
    end
  end

  // Read muxes; address 0 falls through to the zero default.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (bus.rna == AW'(i)) rd_a = regs[i];
      if (bus.rnb == AW'(i)) rd_b = regs[i];
    end
  end

  // Forwarding is suppressed during reset so both ports read zero.
  assign fwd_a = BYPASS && clrn && wr_valid_c && (bus.wn == bus.rna);
  assign fwd_b = BYPASS && clrn && wr_valid_c && (bus.wn == bus.rnb);

  assign bus.qa = fwd_a ? bus.d : rd_a;
  assign bus.qb = fwd_b ? bus.d : rd_b;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: one forwarding and one non-forwarding
// instance share identical stimulus.
module tb_regfile_2r1w;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          clrn;
  logic          we;
  logic [AW-1:0] wn;
  logic [DW-1:0] d;
  logic [AW-1:0] rna;
  logic [AW-1:0] rnb;

  int n_cmp;
  int n_bad;
  logic [DW-1:0] exp_r [32];

  regfile_2r1w_if #(.DW(DW), .AW(AW)) bus_b ();
  regfile_2r1w_if #(.DW(DW), .AW(AW)) bus_n ();

  assign bus_b.we = we;  assign bus_b.wn = wn;  assign bus_b.d = d;
  assign bus_b.rna = rna; assign bus_b.rnb = rnb;
  assign bus_n.we = we;  assign bus_n.wn = wn;  assign bus_n.d = d;
  assign bus_n.rna = rna; assign bus_n.rnb = rnb;

  regfile_2r1w #(.DW(DW), .AW(AW), .BYPASS(1'b1)) u_byp (
    .clk(clk), .clrn(clrn), .bus(bus_b)
  );
  regfile_2r1w #(.DW(DW), .AW(AW), .BYPASS(1'b0)) u_nob (
    .clk(clk), .clrn(clrn), .bus(bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    we = 1'b1; wn = a; d = v;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0; we = 1'b0; wn = '0; d = '0; rna = '0; rnb = '0;
    #2;
    for (int a = 0; a < 32; a++) begin
      rna = AW'(a); rnb = AW'(31 - a);
      #1;
      n_cmp++;
      if (bus_b.qa !== 32'h0 || bus_b.qb !== 32'h0 || bus_n.qa !== 32'h0 || bus_n.qb !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_read r%0d: got %h/%h/%h/%h required 0", a, bus_b.qa, bus_b.qb, bus_n.qa, bus_n.qb);
      end
    end
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_basic_write();
    do_write(5'd5, 32'hFFFF_FFFF);
    rna = 5'd5; rnb = 5'd0;
    #1;
    n_cmp++;
    if (bus_b.qa !== 32'hFFFF_FFFF || bus_n.qa !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL write_r5 qa: got %h/%h required ffffffff", bus_b.qa, bus_n.qa);
    end
    n_cmp++;
    if (bus_b.qb !== 32'h0 || bus_n.qb !== 32'h0) begin
      n_bad++;
      $display("FAIL read_r0 qb: got %h/%h required 00000000", bus_b.qb, bus_n.qb);
    end
  endtask

  task automatic test_r0_write();
    do_write(5'd0, 32'h5555_5555);
    rna = 5'd0; rnb = 5'd0;
    #1;
    n_cmp++;
    if (bus_b.qa !== 32'h0 || bus_n.qa !== 32'h0 || bus_b.qb !== 32'h0) begin
      n_bad++;
      $display("FAIL r0_write: got %h/%h/%h required 00000000", bus_b.qa, bus_n.qa, bus_b.qb);
    end
    // WN=0 with matching RN must not forward either
    @(negedge clk);
    we = 1'b1; wn = 5'd0; d = 32'h1234_5678; rna = 5'd0;
    #1;
    n_cmp++;
    if (bus_b.qa !== 32'h0) begin
      n_bad++;
      $display("FAIL r0_no_forward: got %h required 00000000", bus_b.qa);
    end
    we = 1'b0;
  endtask

  task automatic test_bypass();
    do_write(5'd7, 32'h5555_5555);
    @(negedge clk);
    we = 1'b1; wn = 5'd7; d = 32'hAAAA_AAAA; rna = 5'd7; rnb = 5'd7;
    #1;
    n_cmp++;
    if (bus_b.qa !== 32'hAAAA_AAAA || bus_b.qb !== 32'hAAAA_AAAA) begin
      n_bad++;
      $display("FAIL bypass_pre_edge: got %h/%h required aaaaaaaa", bus_b.qa, bus_b.qb);
    end
    n_cmp++;
    if (bus_n.qa !== 32'h5555_5555 || bus_n.qb !== 32'h5555_5555) begin
      n_bad++;
      $display("FAIL nobypass_pre_edge: got %h/%h required 55555555", bus_n.qa, bus_n.qb);
    end
    // Forwarding requires WE: dropping it shows the stored value
    we = 1'b0;
    #1;
    n_cmp++;
    if (bus_b.qa !== 32'h5555_5555) begin
      n_bad++;
      $display("FAIL bypass_we_low: got %h required 55555555", bus_b.qa);
    end
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    n_cmp++;
    if (bus_b.qa !== 32'hAAAA_AAAA || bus_n.qa !== 32'hAAAA_AAAA || bus_n.qb !== 32'hAAAA_AAAA) begin
      n_bad++;
      $display("FAIL post_edge_r7: got %h/%h/%h required aaaaaaaa", bus_b.qa, bus_n.qa, bus_n.qb);
    end
  endtask

  task automatic test_we_low_and_reset_pulse();
    @(negedge clk);
    we = 1'b0; wn = 5'd9; d = 32'h1234_5678;
    @(posedge clk);
    #1;
    rna = 5'd9;
    #1;
    n_cmp++;
    if (bus_b.qa !== 32'h0 || bus_n.qa !== 32'h0) begin
      n_bad++;
      $display("FAIL we_low_r9: got %h/%h required 00000000", bus_b.qa, bus_n.qa);
    end
    // X address with WE low must not disturb anything
    @(negedge clk);
    wn = 'x; d = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rna = 5'd5; rnb = 5'd7;
    #1;
    n_cmp++;
    if (bus_n.qa !== 32'hFFFF_FFFF || bus_n.qb !== 32'hAAAA_AAAA) begin
      n_bad++;
      $display("FAIL x_wn_we_low: got %h/%h required ffffffff/aaaaaaaa", bus_n.qa, bus_n.qb);
    end
    // Reset asserted mid-cycle while a write is pending
    @(negedge clk);
    we = 1'b1; wn = 5'd9; d = 32'h1234_5678; rna = 5'd9; rnb = 5'd5;
    #2;
    clrn = 1'b0;
    #1;
    n_cmp++;
    if (bus_b.qa !== 32'h0 || bus_b.qb !== 32'h0 || bus_n.qb !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_pulse_immediate: got %h/%h/%h required 0", bus_b.qa, bus_b.qb, bus_n.qb);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    #1;
    for (int a = 0; a < 32; a++) begin
      rna = AW'(a); rnb = AW'(a);
      #1;
      n_cmp++;
      if (bus_b.qa !== 32'h0 || bus_n.qb !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_pulse_r%0d: got %h/%h required 0", a, bus_b.qa, bus_n.qb);
      end
    end
  endtask

  task automatic test_all_regs();
    exp_r[0] = '0;
    for (int i = 1; i < 32; i++) begin
      exp_r[i] = 32'(i) * 32'h0101_0101;
      do_write(AW'(i), exp_r[i]);
    end
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        rna = AW'(a); rnb = AW'(b);
        #1;
        n_cmp++;
        if (bus_b.qa !== exp_r[a] || bus_b.qb !== exp_r[b] ||
            bus_n.qa !== exp_r[a] || bus_n.qb !== exp_r[b]) begin
          n_bad++;
          $display("FAIL pair_r%0d_r%0d: got %h/%h/%h/%h required %h/%h",
                   a, b, bus_b.qa, bus_b.qb, bus_n.qa, bus_n.qb, exp_r[a], exp_r[b]);
        end
      end
    end
  endtask

  task automatic test_async_clear();
    for (int i = 1; i < 32; i += 3) do_write(AW'(i), $urandom() | 32'h1);
    @(negedge clk);
    #2;
    rna = 5'd1; rnb = 5'd4;
    clrn = 1'b0;
    #1;
    n_cmp++;
    if (bus_b.qa !== 32'h0 || bus_b.qb !== 32'h0 || bus_n.qa !== 32'h0 || bus_n.qb !== 32'h0) begin
      n_bad++;
      $display("FAIL async_clear_no_edge: got %h/%h/%h/%h required 0", bus_b.qa, bus_b.qb, bus_n.qa, bus_n.qb);
    end
    for (int a = 0; a < 32; a++) begin
      rna = AW'(a); rnb = AW'(31 - a);
      #1;
      n_cmp++;
      if (bus_b.qa !== 32'h0 || bus_n.qa !== 32'h0 || bus_n.qb !== 32'h0) begin
        n_bad++;
        $display("FAIL async_clear_r%0d: got %h/%h/%h required 0", a, bus_b.qa, bus_n.qa, bus_n.qb);
      end
    end
    @(negedge clk);
    clrn = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic_write();
    test_r0_write();
    test_bypass();
    test_we_low_and_reset_pulse();
    test_all_regs();
    test_async_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
